// File: rtl/aes_key_expander.sv
// AES key schedule: expands a 128- or 256-bit cipher key into 11 or 15 round
// keys held in an internal key memory. The round logic reads the memory
// combinationally through round/round_key. While the expansion runs, this
// block drives the shared S-box word (sboxw -> new_sboxw, same cycle).
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   init       one-cycle start pulse, accepted only while ready=1
//   keylen     0 = AES-128, 1 = AES-256, sampled on accepted init
//   key        cipher key (AES-128 uses key[255:128]), sampled on accepted init
//   round      round-key index to read
//   round_key  key_mem[round]; index 15 reads as zero
//   ready      idle and key memory valid
//   sboxw      word sent to the shared S-box (zero when unused)
//   new_sboxw  S-box result for sboxw
module aes_key_expander (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_GENERATE,
    CTRL_DONE
  } ctrl_state_t;

  ctrl_state_t  state, state_next;

  logic [127:0] key_mem [0:14];
  logic [255:0] key_reg;
  logic         keylen_reg;
  logic [3:0]   round_ctr;
  logic [7:0]   rcon;
  logic         ready_reg;
  // prev_w: most recently written entry; prev_p: the entry before that.
  logic [127:0] prev_w;
  logic [127:0] prev_p;

  logic         init_accept;
  logic         mem_we;
  logic         rcon_we;
  logic [127:0] new_key;
  logic [127:0] base;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [7:0]   rcon_next;
  logic [3:0]   last_round;
  logic         is_256;

  assign is_256     = (keylen_reg == AES_256_BIT_KEY);
  assign last_round = is_256 ? AES256_ROUNDS : AES128_ROUNDS;
  assign rcon_next  = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});

  assign ready     = ready_reg;
  assign round_key = (round == 4'hf) ? '0 : key_mem[round];

  always_comb begin
    state_next  = state;
    init_accept = 1'b0;
    mem_we      = 1'b0;
    rcon_we     = 1'b0;
    sboxw       = '0;
    new_key     = '0;
    base        = '0;
    t           = '0;
    n0          = '0;
    n1          = '0;
    n2          = '0;
    n3          = '0;

    case (state)
      CTRL_IDLE: begin
        if (init) begin
          init_accept = 1'b1;
          state_next  = CTRL_GENERATE;
        end
      end

      CTRL_GENERATE: begin
        mem_we = 1'b1;
        if (round_ctr == 4'd0) begin
          new_key = key_reg[255:128];
        end else if (is_256 && (round_ctr == 4'd1)) begin
          new_key = key_reg[127:0];
        end else begin
          sboxw = prev_w[31:0];
          // AES-128 uses rotation+rcon every round; AES-256 only on even rounds,
          // odd rounds take the plain SubWord result.
          if (!is_256 || !round_ctr[0]) begin
            t       = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_next, 24'h0};
            rcon_we = 1'b1;
          end else begin
            t = new_sboxw;
          end
          base    = is_256 ? prev_p : prev_w;
          n0      = base[127:96] ^ t;
          n1      = base[95:64]  ^ n0;
          n2      = base[63:32]  ^ n1;
          n3      = base[31:0]   ^ n2;
          new_key = {n0, n1, n2, n3};
        end
        if (round_ctr == last_round) begin
          state_next = CTRL_DONE;
        end
      end

      CTRL_DONE: begin
        state_next = CTRL_IDLE;
      end

      default: begin
        state_next = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CTRL_IDLE;
      key_reg    <= '0;
      keylen_reg <= AES_128_BIT_KEY;
      round_ctr  <= '0;
      rcon       <= 8'h8d;
      ready_reg  <= 1'b1;
      prev_w     <= '0;
      prev_p     <= '0;
      for (int unsigned i = 0; i < 15; i++) begin
        key_mem[i] <= '0;
      end
    end else begin
      state <= state_next;

      if (init_accept) begin
        key_reg    <= key;
        keylen_reg <= keylen;
        round_ctr  <= '0;
        rcon       <= 8'h8d;
        ready_reg  <= 1'b0;
      end

      if (mem_we) begin
        key_mem[round_ctr] <= new_key;
        prev_p             <= prev_w;
        prev_w             <= new_key;
        round_ctr          <= round_ctr + 4'd1;
      end

      if (rcon_we) begin
        rcon <= rcon_next;
      end

      if (state == CTRL_DONE) begin
        ready_reg <= 1'b1;
      end
    end
  end

endmodule
